// File: rtl/aes_ecb_dec.sv
// aes_ecb_dec: inverse-XOR decrypt stage with global-stall pipeline and framing check (AES_DEC_FRAME_CHECK_EN)
module aes_ecb_dec #(
  parameter int NUM_STAGES = 10,
  parameter int CNT_W      = 16,
  parameter int DATA_W     = 128,
  parameter int EMPTY_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in_data,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               data_in_sop,
  input  logic               data_in_eop,
  input  logic [EMPTY_W-1:0] data_in_empty,
  output logic [DATA_W-1:0]  data_out_data,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               data_out_sop,
  output logic               data_out_eop,
  output logic [EMPTY_W-1:0] data_out_empty,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic               err_orphan,
  output logic               err_sop,
  output logic               err_sticky
);
  logic [NUM_STAGES-1:0]              st_vld, st_sop, st_eop;
  logic [NUM_STAGES-1:0][DATA_W-1:0]  st_dat;
  logic [NUM_STAGES-1:0][EMPTY_W-1:0] st_emp;
  logic adv, accept, drop;
  assign adv            = ~st_vld[NUM_STAGES-1] | data_out_ready;
  assign data_in_ready  = adv;
  assign accept         = data_in_valid & adv;
  assign data_out_valid = st_vld[NUM_STAGES-1];
  assign data_out_data  = st_dat[NUM_STAGES-1];
  assign data_out_sop   = st_sop[NUM_STAGES-1];
  assign data_out_eop   = st_eop[NUM_STAGES-1];
  assign data_out_empty = st_emp[NUM_STAGES-1];
  // whole pipeline shifts together on adv, otherwise every stage holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_vld <= '0;
      st_sop <= '0;
      st_eop <= '0;
      st_dat <= '0;
      st_emp <= '0;
    end else if (adv) begin
      for (int i = NUM_STAGES - 1; i > 0; i--) begin
        st_vld[i] <= st_vld[i-1];
        st_sop[i] <= st_sop[i-1];
        st_eop[i] <= st_eop[i-1];
        st_dat[i] <= st_dat[i-1];
        st_emp[i] <= st_emp[i-1];
      end
      st_vld[0] <= accept & ~drop;
      st_sop[0] <= data_in_sop;
      st_eop[0] <= data_in_eop;
      st_dat[0] <= ~data_in_data;
      st_emp[0] <= data_in_empty;
    end
  // count delivered packet ends, wrapping naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_cnt <= '0;
    else if (data_out_valid & data_out_ready & data_out_eop) pkt_cnt <= pkt_cnt + 1'b1;
`ifdef AES_DEC_FRAME_CHECK_EN
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nxt;
  logic orphan_nxt, sop_err_nxt;
  // framing state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // framing decisions on each accepted beat; orphans are swallowed
  always_comb begin
    state_nxt   = state;
    drop        = 1'b0;
    orphan_nxt  = 1'b0;
    sop_err_nxt = 1'b0;
    if (accept) begin
      if (state == IDLE && !data_in_sop) begin
        drop       = 1'b1;
        orphan_nxt = 1'b1;
      end else begin
        sop_err_nxt = (state == PKT) & data_in_sop;
        state_nxt   = data_in_eop ? IDLE : PKT;
      end
    end
  end
  // error pulses one cycle after accept; sticky set has priority over clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_orphan <= 1'b0;
      err_sop    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_orphan <= orphan_nxt;
      err_sop    <= sop_err_nxt;
      err_sticky <= orphan_nxt | sop_err_nxt | (err_sticky & ~clr_err);
    end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign drop       = 1'b0;
  assign err_orphan = 1'b0;
  assign err_sop    = 1'b0;
  assign err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_aes_ecb_dec.sv
// tb_aes_ecb_dec: randomized self-checking bench with a queue-based reference model
module tb_aes_ecb_dec;
  logic clk = 0, rst_n = 0;
  logic [127:0] data_in_data = '0;
  logic data_in_valid = 0, data_in_sop = 0, data_in_eop = 0, data_out_ready = 1, clr_err = 0;
  logic [3:0] data_in_empty = '0;
  logic data_in_ready, data_out_valid, data_out_sop, data_out_eop;
  logic [127:0] data_out_data;
  logic [3:0] data_out_empty;
  logic [15:0] pkt_cnt;
  logic err_orphan, err_sop, err_sticky;
  logic d2_in_ready, d2_valid, d2_sop, d2_eop, d2_orphan, d2_err_sop, d2_sticky;
  logic [127:0] d2_data;
  logic [3:0] d2_empty;
  logic [1:0] d2_pkt_cnt;

  aes_ecb_dec dut (.clk(clk), .rst_n(rst_n), .data_in_data(data_in_data), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_in_sop(data_in_sop), .data_in_eop(data_in_eop),
    .data_in_empty(data_in_empty), .data_out_data(data_out_data), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_sop(data_out_sop), .data_out_eop(data_out_eop),
    .data_out_empty(data_out_empty), .clr_err(clr_err), .pkt_cnt(pkt_cnt), .err_orphan(err_orphan),
    .err_sop(err_sop), .err_sticky(err_sticky));

  aes_ecb_dec #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .data_in_data(data_in_data),
    .data_in_valid(data_in_valid), .data_in_ready(d2_in_ready), .data_in_sop(data_in_sop),
    .data_in_eop(data_in_eop), .data_in_empty(data_in_empty), .data_out_data(d2_data),
    .data_out_valid(d2_valid), .data_out_ready(data_out_ready), .data_out_sop(d2_sop),
    .data_out_eop(d2_eop), .data_out_empty(d2_empty), .clr_err(clr_err), .pkt_cnt(d2_pkt_cnt),
    .err_orphan(d2_orphan), .err_sop(d2_err_sop), .err_sticky(d2_sticky));

  always #5 clk = ~clk;

  typedef struct packed {logic [127:0] d; logic s; logic e; logic [3:0] m;} beat_t;
  beat_t q[$];
  beat_t cur, prev, want;
  bit in_pkt = 0, stall_prev = 0, fwd;
  int tests = 0, fails = 0;
  int orphan_cnt = 0, sop_cnt = 0, out_cnt = 0;
  int rmode = 0, pcnt = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // sink ready generator: 0 always, 1 pattern 1,0,0,1, 2 random
  always @(posedge clk) begin
    #1;
    pcnt++;
    if (rmode == 0) data_out_ready = 1;
    else if (rmode == 1) data_out_ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
    else data_out_ready = ($urandom_range(0, 9) < 7);
  end

  // reference model: every forwarded beat comes out inverted, in order, unchanged framing
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_in_valid && data_in_ready) begin
        fwd = 1;
`ifdef AES_DEC_FRAME_CHECK_EN
        fwd = in_pkt || data_in_sop;
        if (fwd) in_pkt = !data_in_eop;
`endif
        if (fwd) q.push_back('{~data_in_data, data_in_sop, data_in_eop, data_in_empty});
      end
      cur = '{data_out_data, data_out_sop, data_out_eop, data_out_empty};
      tests++;
      if (data_in_ready !== !(data_out_valid && !data_out_ready)) begin
        fails++;
        $display("FAIL mon_ready got %b want %b", data_in_ready, !(data_out_valid && !data_out_ready));
      end
      if (stall_prev) begin
        tests++;
        if (!data_out_valid || cur !== prev) begin
          fails++;
          $display("FAIL mon_stall_hold got v=%b %h want %h", data_out_valid, cur, prev);
        end
      end
      if (data_out_valid && data_out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL mon_spurious got %h want no beat", cur);
        end else begin
          want = q.pop_front();
          if (cur !== want) begin
            fails++;
            $display("FAIL mon_beat got %h want %h", cur, want);
          end
        end
      end
      stall_prev = data_out_valid && !data_out_ready;
      prev = cur;
      orphan_cnt += int'(err_orphan);
      sop_cnt += int'(err_sop);
      out_cnt += int'(data_out_valid && data_out_ready);
    end else stall_prev = 0;
  end

  task automatic send_beat(input logic [127:0] d, input logic s, input logic e, input logic [3:0] m);
    bit ok;
    data_in_data = d; data_in_sop = s; data_in_eop = e; data_in_empty = m; data_in_valid = 1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      ok = data_in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    fails++;
    $display("FAIL send_timeout got no ready want ready");
  endtask

  task automatic idle_in();
    data_in_valid = 0; data_in_sop = 0; data_in_eop = 0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 2000; n++) begin
      if (q.size() == 0 && !data_out_valid) break;
      @(posedge clk);
      #1;
    end
    tests++;
    if (n == 2000) begin
      fails++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({data_out_valid, data_out_sop, data_out_eop, data_out_empty, data_out_data} !== '0 ||
        pkt_cnt !== 16'd0 || {err_orphan, err_sop, err_sticky} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs got v=%b cnt=%0d err=%b want all 0", data_out_valid, pkt_cnt,
               {err_orphan, err_sop, err_sticky});
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    tests++;
    if (data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", data_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [127:0] d [4];
    logic [3:0] m [4];
    logic [15:0] c0 = pkt_cnt;
    d[0] = '0; d[1] = '1; d[2] = 128'h0123456789abcdef0123456789abcdef; d[3] = {4{32'ha5a5a5a5}};
    for (int k = 0; k < 4; k++) m[k] = 4'($urandom_range(0, 15));
    rmode = 0;
    for (int k = 0; k < 4; k++) send_beat(d[k], k == 0, k == 3, m[k]);
    idle_in();
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests++;
    if (data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early got %b want 0", data_out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (data_out_valid !== 1'b1 || data_out_data !== ~d[k] || data_out_sop !== (k == 0) ||
          data_out_eop !== (k == 3) || data_out_empty !== m[k]) begin
        fails++;
        $display("FAIL basic_beat%0d got v=%b %h s=%b e=%b m=%h want %h m=%h", k, data_out_valid,
                 data_out_data, data_out_sop, data_out_eop, data_out_empty, ~d[k], m[k]);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (pkt_cnt !== c0 + 16'd1) begin
      fails++;
      $display("FAIL basic_pkt_cnt got %0d want %0d", pkt_cnt, c0 + 16'd1);
    end
  endtask

  task automatic test_roundtrip();
    int beats = 0, o0 = out_cnt;
    logic [15:0] c0 = pkt_cnt;
    rmode = 2;
    for (int p = 0; p < 100; p++) begin
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send_beat(~rnd128(), b == 0, b == len - 1, 4'($urandom_range(0, 15)));
        beats++;
      end
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        @(posedge clk);
        #1;
      end
    end
    idle_in();
    drain();
    tests++;
    if (out_cnt - o0 !== beats) begin
      fails++;
      $display("FAIL roundtrip_count got %0d want %0d", out_cnt - o0, beats);
    end
    tests++;
    if (pkt_cnt !== c0 + 16'd100) begin
      fails++;
      $display("FAIL roundtrip_pkt_cnt got %0d want %0d", pkt_cnt, c0 + 16'd100);
    end
    rmode = 0;
  endtask

  task automatic test_back_to_back();
    int o0 = out_cnt;
    rmode = 1;
    for (int k = 0; k < 40; k++) send_beat(rnd128(), k % 4 == 0, k % 4 == 3, 4'(k));
    idle_in();
    drain();
    tests++;
    if (out_cnt - o0 !== 40) begin
      fails++;
      $display("FAIL backpressure_count got %0d want 40", out_cnt - o0);
    end
    rmode = 0;
  endtask

  task automatic test_framing();
    int or0 = orphan_cnt, so0 = sop_cnt, o0 = out_cnt;
    logic [15:0] c0 = pkt_cnt;
    int exp_orphan = 0, exp_sop = 0, exp_out = 5;
    logic exp_sticky = 0;
`ifdef AES_DEC_FRAME_CHECK_EN
    exp_orphan = 1; exp_sop = 1; exp_out = 4; exp_sticky = 1;
`endif
    send_beat(rnd128(), 0, 0, 4'd0);
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (orphan_cnt - or0 !== exp_orphan || err_sticky !== exp_sticky) begin
      fails++;
      $display("FAIL orphan_err got pulses=%0d sticky=%b want %0d %b", orphan_cnt - or0, err_sticky,
               exp_orphan, exp_sticky);
    end
    clr_err = 1;
    @(posedge clk);
    #1;
    clr_err = 0;
    tests++;
    if (err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL clr_err got %b want 0", err_sticky);
    end
    send_beat(rnd128(), 1, 0, 4'd1);
    send_beat(rnd128(), 0, 0, 4'd2);
    send_beat(rnd128(), 1, 0, 4'd3);
    send_beat(rnd128(), 0, 1, 4'd4);
    idle_in();
    drain();
    tests++;
    if (sop_cnt - so0 !== exp_sop || err_sticky !== exp_sticky || orphan_cnt - or0 !== exp_orphan) begin
      fails++;
      $display("FAIL sop_err got pulses=%0d sticky=%b orphans=%0d want %0d %b %0d", sop_cnt - so0,
               err_sticky, orphan_cnt - or0, exp_sop, exp_sticky, exp_orphan);
    end
    tests++;
    if (out_cnt - o0 !== exp_out || pkt_cnt !== c0 + 16'd1) begin
      fails++;
      $display("FAIL framing_fwd got beats=%0d cnt=%0d want %0d %0d", out_cnt - o0, pkt_cnt, exp_out,
               c0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [5];
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;
    rmode = 0;
    for (int k = 0; k < 12; k++) send_beat(rnd128(), 1, 1, 4'd0);
    idle_in();
    rst_n = 0;
    #1;
    tests++;
    if (data_out_valid !== 1'b0 || pkt_cnt !== 16'd0 || d2_pkt_cnt !== 2'd0 || data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid got v=%b cnt=%0d cnt2=%0d rdy=%b want 0 0 0 1", data_out_valid, pkt_cnt,
               d2_pkt_cnt, data_in_ready);
    end
    q.delete();
    in_pkt = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      send_beat(rnd128(), 1, 1, 4'(k));
      idle_in();
      drain();
      tests++;
      if (d2_pkt_cnt !== seq[k] || pkt_cnt !== 16'(k + 1)) begin
        fails++;
        $display("FAIL wrap_cnt%0d got %0d/%0d want %0d/%0d", k, d2_pkt_cnt, pkt_cnt, seq[k], k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_roundtrip();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
